// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared control definitions for the multicycle CPU: the main control FSM
// state encoding, the opcodes it decodes, the datapath select encodings
// (ALUSrcA / ALUSrcB / ResultSrc / AluOp) and the DECODE dispatch function.
//
// Optional feature macro: LUI_EN adds the LUI state and the 0110111 opcode.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef LUI_EN
    , S_LUI    = 4'd11
`endif
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef LUI_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
`endif

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // AluOp class handed to alu_decoders
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // State entered from DECODE for a given opcode; S_FETCH means unsupported.
  function automatic state_t decode_target(input logic [6:0] opcode);
    state_t tgt;
    case (opcode)
      OP_LOAD, OP_STORE: tgt = S_MEMADR;
      OP_RTYPE:          tgt = S_EXECUTER;
      OP_ITYPE:          tgt = S_EXECUTEI;
      OP_BEQ:            tgt = S_BEQ;
      OP_JAL:            tgt = S_JAL;
`ifdef LUI_EN
      OP_LUI:            tgt = S_LUI;
`endif
      default:           tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm
// Main control state machine of the multicycle CPU. Sequences fetch, decode,
// memory, ALU, branch and jump steps and drives the datapath enables/selects.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   op[6:0]    in   opcode from the instruction register
//   mem_ready  in   memory completes the current access this cycle
//   AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch   out  enables/selects
//   ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], AluOp[1:0] out  datapath selects
//   illegal_op out  one-cycle pulse in DECODE for an unsupported opcode
//   retire     out  one-cycle pulse on the cycle an instruction completes
//
// Optional feature macro: LUI_EN (adds the LUI state).
// ---------------------------------------------------------------------------
module main_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] AluOp,
  output logic       illegal_op,
  output logic       retire
);

  state_t state;
  state_t next_state;

  // Raw enables before reset gating
  logic ir_write;
  logic pc_update;
  logic reg_write;
  logic mem_write;
  logic branch;
  logic illegal;
  logic done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   next_state = decode_target(op);
      S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
`ifdef LUI_EN
      S_LUI:      next_state = S_ALUWB;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode per state
  always_comb begin
    AdrSrc    = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    done      = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AluOp     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_write  = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = (decode_target(op) == S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = mem_ready;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        AluOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        AluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        AluOp   = ALUOP_BRANCH;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
`ifdef LUI_EN
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
`endif
      default: begin
        AdrSrc = 1'b0;
      end
    endcase
  end

  // Enables are forced low for as long as reset is held, not just at the edge
  assign IRWrite    = ir_write  & rst_n;
  assign PCUpdate   = pc_update & rst_n;
  assign RegWrite   = reg_write & rst_n;
  assign MemWrite   = mem_write & rst_n;
  assign Branch     = branch    & rst_n;
  assign illegal_op = illegal   & rst_n;
  assign retire     = done      & rst_n;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_ctrl_fsm
// Scripted scenarios: each cycle's expected output vector is queued as the
// stimulus is applied and compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_main_ctrl_fsm;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_RTYPE = 7'b0110011;
  localparam logic [6:0] T_ITYPE = 7'b0010011;
  localparam logic [6:0] T_BEQ   = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  // Enable bits (incl. illegal_op/retire) and enables plus AdrSrc
  localparam logic [15:0] EN_MASK     = 16'h7C03;
  localparam logic [15:0] EN_ADR_MASK = 16'hFC03;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, AluOp;
  logic       illegal_op, retire;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] obs;

  main_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AluOp(AluOp), .illegal_op(illegal_op), .retire(retire)
  );

  always #5 clk = ~clk;

  assign obs = {AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch,
                ALUSrcA, ALUSrcB, ResultSrc, AluOp, illegal_op, retire};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Scoreboard: pop and compare one expectation per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, obs, e);
    end
  end

  function automatic logic [15:0] v(input logic adr, input logic irw, input logic pcu,
                                    input logic rw, input logic mw, input logic br,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] r, input logic [1:0] aop,
                                    input logic ill, input logic ret);
    return {adr, irw, pcu, rw, mw, br, a, b, r, aop, ill, ret};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return v(1'b0, mr, mr, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, ill, 1'b0);
  endfunction
  function automatic logic [15:0] e_memadr();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] e_memread();
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] e_memwb();
    return v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
  endfunction
  function automatic logic [15:0] e_memwrite(input logic mr);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mr);
  endfunction
  function automatic logic [15:0] e_execr();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] e_execi();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] e_aluwb();
    return v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
  endfunction
  function automatic logic [15:0] e_beq();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
  endfunction
  function automatic logic [15:0] e_jal();
    return v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
`ifdef LUI_EN
  function automatic logic [15:0] e_lui();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
`endif

  // Apply one cycle of stimulus, queue its expectation, advance to next cycle
  task automatic step(input logic mr, input logic [6:0] o, input logic [15:0] e, input string tag);
    op        = o;
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op        = T_RTYPE;
    mem_ready = 1'b1;
    #12;
    check_val("reset_enables", obs & EN_MASK, 16'h0000);
    @(posedge clk);
    #1;
    check_val("reset_enables_hold", obs & EN_MASK, 16'h0000);
    rst_n     = 1'b1;

    // Fetch stalls while memory not ready, then R-type; op noise outside DECODE
    step(1'b0, T_BAD,   e_fetch(1'b0), "fetch_stall");
    step(1'b0, T_LOAD,  e_fetch(1'b0), "fetch_stall2");
    step(1'b1, T_BAD,   e_fetch(1'b1), "r_fetch");
    step(1'b1, T_RTYPE, e_decode(1'b0), "r_decode");
    step(1'b1, T_LOAD,  e_execr(),     "r_execr");
    step(1'b1, T_BAD,   e_aluwb(),     "r_aluwb");

    // Load with 3 wait cycles in MEMREAD; op change there has no effect
    step(1'b1, T_LOAD,  e_fetch(1'b1), "ld_fetch");
    step(1'b0, T_LOAD,  e_decode(1'b0), "ld_decode");
    step(1'b0, T_LOAD,  e_memadr(),    "ld_memadr");
    step(1'b0, T_STORE, e_memread(),   "ld_wait1");
    step(1'b0, T_STORE, e_memread(),   "ld_wait2");
    step(1'b0, T_STORE, e_memread(),   "ld_wait3");
    step(1'b1, T_STORE, e_memread(),   "ld_done");
    step(1'b1, T_STORE, e_memwb(),     "ld_memwb");

    // Store: MemWrite held until ready, retire only on the completing cycle
    step(1'b1, T_STORE, e_fetch(1'b1), "st_fetch");
    step(1'b1, T_STORE, e_decode(1'b0), "st_decode");
    step(1'b0, T_STORE, e_memadr(),    "st_memadr");
    step(1'b0, T_LOAD,  e_memwrite(1'b0), "st_wait1");
    step(1'b0, T_LOAD,  e_memwrite(1'b0), "st_wait2");
    step(1'b1, T_LOAD,  e_memwrite(1'b1), "st_done");

    // Illegal opcode: one-cycle pulse, no retire, back to FETCH
    step(1'b1, T_BAD,   e_fetch(1'b1), "ill_fetch");
    step(1'b1, T_BAD,   e_decode(1'b1), "ill_decode");

    // I-type
    step(1'b1, T_ITYPE, e_fetch(1'b1), "i_fetch");
    step(1'b1, T_ITYPE, e_decode(1'b0), "i_decode");
    step(1'b1, T_ITYPE, e_execi(),     "i_execi");
    step(1'b1, T_ITYPE, e_aluwb(),     "i_aluwb");

    // Branch
    step(1'b1, T_BEQ,   e_fetch(1'b1), "beq_fetch");
    step(1'b1, T_BEQ,   e_decode(1'b0), "beq_decode");
    step(1'b1, T_BEQ,   e_beq(),       "beq_exec");

    // Jump
    step(1'b1, T_JAL,   e_fetch(1'b1), "jal_fetch");
    step(1'b1, T_JAL,   e_decode(1'b0), "jal_decode");
    step(1'b1, T_JAL,   e_jal(),       "jal_exec");
    step(1'b1, T_JAL,   e_aluwb(),     "jal_aluwb");

    // LUI: dedicated path when enabled, illegal otherwise
    step(1'b1, T_LUI,   e_fetch(1'b1), "lui_fetch");
`ifdef LUI_EN
    step(1'b1, T_LUI,   e_decode(1'b0), "lui_decode");
    step(1'b1, T_LUI,   e_lui(),       "lui_exec");
    step(1'b1, T_LUI,   e_aluwb(),     "lui_aluwb");
`else
    step(1'b1, T_LUI,   e_decode(1'b1), "lui_illegal");
`endif

    // Reset asserted mid-MEMREAD: access abandoned at once
    step(1'b1, T_LOAD,  e_fetch(1'b1), "rr_fetch");
    step(1'b0, T_LOAD,  e_decode(1'b0), "rr_decode");
    step(1'b0, T_LOAD,  e_memadr(),    "rr_memadr");
    step(1'b0, T_LOAD,  e_memread(),   "rr_memread");
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_read", obs & EN_ADR_MASK, 16'h0000);
    @(posedge clk);
    #1;
    check_val("rst_mid_hold", obs & EN_ADR_MASK, 16'h0000);
    rst_n = 1'b1;
    step(1'b0, T_RTYPE, e_fetch(1'b0), "post_rst_fetch0");
    step(1'b1, T_RTYPE, e_fetch(1'b1), "post_rst_fetch");
    step(1'b1, T_RTYPE, e_decode(1'b0), "post_rst_decode");
    step(1'b1, T_RTYPE, e_execr(),     "post_rst_execr");
    step(1'b1, T_RTYPE, e_aluwb(),     "post_rst_aluwb");
    step(1'b0, T_RTYPE, e_fetch(1'b0), "post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
